// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-bank receiver: register map,
// frame length and the frame FSM state encoding.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_OUT_LO = 7'd0;
  localparam logic [6:0] ADDR_OUT_HI = 7'd1;
  localparam logic [6:0] ADDR_PWM_LO = 7'd2;
  localparam logic [6:0] ADDR_PWM_HI = 7'd3;
  localparam logic [6:0] ADDR_DUTY   = 7'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings one asynchronous SPI pin into the clk domain: a SYNC_STAGES flop
// chain followed by a history flop, so edges are seen from the last two flops.
// Everything resets to 0 so a pin that is already low after reset never
// produces a falling edge.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      hist  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      hist  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_reg_bank_rx.sv
// Write-only SPI mode-0 receiver that decodes 16-bit frames
// ({rw, addr[6:0], data[7:0]}) and updates the five PWM control registers.
// All pins are oversampled in the clk domain; SCLK must be at least 8x slower.
module spi_reg_bank_rx
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = spi_reg_pkg::FRAME_BITS,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nCS,
  input  logic       SCLK,
  input  logic       copi,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  localparam int               CNT_W   = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS + 1);

  logic ncs_lvl, ncs_rise, ncs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .pin(nCS),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .pin(SCLK),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .pin(copi),
    .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
  );

  // Only the levels/edges listed above are needed by the frame logic
  logic unused_sync;
  assign unused_sync = &{1'b0, ncs_lvl, sclk_lvl, sclk_fall, copi_rise, copi_fall};

  spi_state_t            state;
  logic [FRAME_BITS-1:0] shift;
  logic [CNT_W-1:0]      cnt;
  logic                  fall_hold;
  logic [6:0]            addr_f;
  logic                  frame_ok;

  assign addr_f   = shift[FRAME_BITS-2 -: 7];
  assign frame_ok = (cnt == CNT_LEN) && shift[FRAME_BITS-1] &&
                    (addr_f <= 7'(MAX_ADDR));

  // Frame FSM, shift register, bit counter and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shift           <= '0;
      cnt             <= '0;
      fall_hold       <= 1'b0;
      wr_strobe       <= 1'b0;
      frame_err       <= 1'b0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // fall_hold covers an nCS fall that arrived while committing
          if (ncs_fall || fall_hold) begin
            state     <= SHIFT;
            shift     <= '0;
            cnt       <= '0;
            fall_hold <= 1'b0;
          end
        end
        SHIFT: begin
          // nCS rise takes priority over a coincident SCLK rise
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise) begin
            shift <= {shift[FRAME_BITS-2:0], copi_lvl};
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (ncs_fall) fall_hold <= 1'b1;
          if (frame_ok) begin
            wr_strobe <= 1'b1;
            case (addr_f)
              ADDR_OUT_LO: en_reg_out_7_0  <= shift[7:0];
              ADDR_OUT_HI: en_reg_out_15_8 <= shift[7:0];
              ADDR_PWM_LO: en_reg_pwm_7_0  <= shift[7:0];
              ADDR_PWM_HI: en_reg_pwm_15_8 <= shift[7:0];
              ADDR_DUTY:   pwm_duty_cycle  <= shift[7:0];
              default: ;
            endcase
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bank_rx.sv
// Bench for spi_reg_bank_rx: directed SPI frames, expected outcome of each
// frame queued at its nCS rise, and a monitor that pops and compares every
// wr_strobe / frame_err pulse against the queue.
module tb_spi_reg_bank_rx;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 5;   // SCLK half period in clk cycles (clk/10)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       nCS, SCLK, copi;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe, frame_err;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic        err;
    logic [39:0] regs;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];

  spi_reg_bank_rx #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BITS(16), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .nCS(nCS), .SCLK(SCLK), .copi(copi),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register snapshot ordered {duty, pwm_hi, pwm_lo, out_hi, out_lo}
  function automatic logic [39:0] regs_now();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      wait_clk(HALF);
      SCLK = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] bits, input int nbits,
                       input logic exp_err, input logic [39:0] exp_regs);
    exp_t e;
    nCS = 1'b0;
    wait_clk(HALF);
    shift_bits(bits, nbits);
    wait_clk(HALF);
    nCS = 1'b1;
    e.err  = exp_err;
    e.regs = exp_regs;
    e.cyc  = cyc;
    exp_q.push_back(e);
    wait_clk(20);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (wr_strobe || frame_err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse wr_strobe=%b frame_err=%b required none", wr_strobe, frame_err);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {38'd0, wr_strobe, frame_err}, {38'd0, ~e.err, e.err});
          check("regs", regs_now(), e.regs);
          check("latency", 40'(cyc - e.cyc), 40'(SYNC_STAGES + 2));
        end
      end
    end
  end

  // Watchdog
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    nCS   = 1'b1;
    SCLK  = 1'b0;
    copi  = 1'b0;
    wait_clk(5);
    check("reset_regs", regs_now(), 40'h0);
    check("reset_pulses", {38'd0, wr_strobe, frame_err}, 40'h0);
    rst_n = 1'b1;
    wait_clk(10);
    check("post_reset_regs", regs_now(), 40'h0);

    // 1: addr 0 <= 0xF0
    frame(32'h80F0, 16, 1'b0, 40'h00_00_00_00_F0);

    // 2: duty <= 0x80 then 0x00
    frame(32'h8480, 16, 1'b0, 40'h80_00_00_00_F0);
    frame(32'h8400, 16, 1'b0, 40'h00_00_00_00_F0);

    // 3: out-of-range address, then a read frame
    frame(32'hB0FF, 16, 1'b1, 40'h00_00_00_00_F0);
    frame(32'h01AB, 16, 1'b1, 40'h00_00_00_00_F0);

    // 4: short frame, then overlong frame whose last 16 bits look valid
    frame(32'h0802, 12, 1'b1, 40'h00_00_00_00_F0);
    frame(32'h08233, 17, 1'b1, 40'h00_00_00_00_F0);

    // 5: bus noise with nCS high, then addr 3 <= 0x5A
    for (int i = 0; i < 20; i++) begin
      copi = i[1];
      SCLK = ~SCLK;
      wait_clk(3);
    end
    SCLK = 1'b0;
    copi = 1'b0;
    wait_clk(10);
    check("noise_ignored", regs_now(), 40'h00_00_00_00_F0);
    frame(32'h835A, 16, 1'b0, 40'h00_5A_00_00_F0);

    // 6: reset after 9 bits, release with nCS low, finish the frame
    nCS = 1'b0;
    wait_clk(HALF);
    shift_bits(32'h81C3 >> 7, 9);
    rst_n = 1'b0;
    wait_clk(3);
    check("midframe_reset_regs", regs_now(), 40'h0);
    rst_n = 1'b1;
    wait_clk(2);
    shift_bits(32'h81C3 & 32'h7F, 7);
    wait_clk(HALF);
    nCS = 1'b1;
    wait_clk(20);
    check("partial_frame_dropped", regs_now(), 40'h0);
    frame(32'h8177, 16, 1'b0, 40'h00_00_00_77_00);

    // Drain: every queued expectation must have been matched
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) wait_clk(1);
    check("queue_drained", 40'(exp_q.size()), 40'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
